// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter with registered, held grant and a hold-limit timeout.
// Priority rotates to just past the releasing requester; hand-over happens with no idle bubble.
module arb8_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IW   = 3;
  localparam int unsigned CW   = 8;
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;

  // First set request at or after 'start', wrapping modulo 8.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     off;
    dbl = {r, r} >> start;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    return IW'(start + off);
  endfunction

  logic            any_req;
  logic            holder_req;
  logic            at_limit;
  logic            release_now;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   idle_win;
  logic [IW-1:0]   rel_win;

  always_comb begin
    any_req     = |req;
    holder_req  = req[gnt_id_q];
    at_limit    = (hold_cnt_q == HOLD_LIMIT);
    release_now = done | ~holder_req | at_limit;
    next_ptr    = IW'(gnt_id_q + IW'(1));
    idle_win    = pick(req, ptr_q);
    rel_win     = pick(req, next_ptr);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_GRANT;
          gnt_d       = NREQ'(1) << idle_win;
          gnt_id_d    = idle_win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = CW'(1);
        end else begin
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end

      S_GRANT: begin
        if (release_now) begin
          ptr_d     = next_ptr;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = at_limit & ~done & holder_req;
          if (any_req) begin
            gnt_d       = NREQ'(1) << rel_win;
            gnt_id_d    = rel_win;
            gnt_valid_d = 1'b1;
            hold_cnt_d  = CW'(1);
          end else begin
            state_d     = S_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else begin
          hold_cnt_d = CW'(hold_cnt_q + CW'(1));
        end
      end

      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/arb8_rr.md
# arb8_rr

Round-robin arbiter that shares one resource among 8 requesters. It uses an 8-input rotating-priority encode with a registered, held grant and a hold timeout. The outputs carry a one-hot grant plus a 3-bit encoded grant index with valid, which is the same encoding the 8-to-3 priority encoders in this design produce. Consumers can therefore use `gnt_id` directly as a mux select.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant is held without release. Legal range 1..255.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request lines. Bit i belongs to requester i. Level-sensitive.
- `done`  in  1: the current holder finishes this cycle. Ignored when `gnt_valid=0`.
- `gnt`  out  8: one-hot grant. All zeros when idle.
- `gnt_id`  out  3: encoded index of the granted requester.
- `gnt_valid`  out  1: a grant is active. Equals OR of `gnt`.
- `timeout`  out  1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- Registers:
  - state: IDLE or GRANT.
  - `ptr[2:0]`: highest-priority index.
  - `hold_cnt[7:0]`.
  - `gnt`, `gnt_id`, `timeout`.
- Arbitration function `pick(req, ptr)`:
  - Scan indices ptr, ptr+1, …, ptr+7, mod 8.
  - Return the first index whose req bit is 1.
  - Result is undefined or unused when req==0.
- IDLE:
  - If req≠0: winner=`pick(req, ptr)`. Next edge: `gnt`=onehot(winner), `gnt_id`=winner, hold_cnt=1, go to GRANT.
  - Otherwise remain in IDLE with outputs zero.
- GRANT, release condition R = `done` | ~`req[gnt_id]` | (hold_cnt==MAX_HOLD).
  - If not R: hold the grant and increment hold_cnt.
  - If R:
    - Set ptr=`gnt_id`+1 mod 8.
    - Re-arbitrate in the same edge with `pick(req, gnt_id+1)` on the current req. The releasing requester is naturally lowest priority.
    - If any req: grant the winner next cycle, hold_cnt=1, stay in GRANT. No bubble.
    - If req==0: clear `gnt`, `gnt_id`=0, go to IDLE.
- Timeout:
  - Set `timeout`=1 for one cycle after a release caused only by the hold limit.
  - Hold limit only means hold_cnt==MAX_HOLD with `done`=0 and `req[gnt_id]`=1.
  - `done` in the limit cycle counts as a normal release, and no timeout is raised.
- ptr changes only on release. A grant from IDLE does not move ptr.
- `gnt` is always one-hot or zero. `gnt_id` is 0 whenever `gnt_valid`=0.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - `gnt`=8'h00, `gnt_id`=3'd0, `gnt_valid`=0, `timeout`=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant drops the grant immediately (asynchronous).
- Latency from req rising in IDLE to `gnt` is 1 clock: sampled at edge N, visible after edge N.
- Hand-over: `done` sampled at edge N means the next grant is visible after edge N. Zero idle cycles between holders.
- Max hold: the grant is visible for exactly MAX_HOLD cycles and then released. `timeout` is high during the first cycle after release.
- If the holder drops req, the grant is released at the next edge, with the same timing as `done`.
- `done` and req drop together count as a single release.
- Simultaneous requests are resolved solely by ptr. Fairness: any continuously asserted request is granted within 7 grants.
- Outputs are registered. No combinational path from `req`/`done` to any output.

## Test plan
- Reset then req=8'h08:
  - `gnt`=8'h08 and `gnt_id`=3 one cycle later, `gnt_valid`=1.
  - Drop req → `gnt`=0 next cycle, `gnt_id`=0.
- req=8'hFF held, `done` pulsed one cycle after each grant:
  - Grant order 0,1,2,…,7,0.
  - No idle cycle between grants.
  - ptr wraps 7→0.
- Grant to 5 with req=8'h21, then `done`:
  - Next grant goes to 0, because the scan starts at 6 and wraps.
  - Subsequent `done` → grant 5.
- MAX_HOLD=4, req=8'h02 held, `done`=0:
  - `gnt`=8'h02 for exactly 4 cycles, then `timeout`=1 for 1 cycle.
  - The grant is re-issued to 1 in that same cycle, since it is the sole requester.
  - A repeat with `done` asserted in cycle 4 gives `timeout`=0.
- `rst_n` asserted while `gnt`=8'h40:
  - All outputs go to 0 immediately, without waiting for a clock.
  - After release with req=8'hC0: grant 6 (ptr reset to 0, so the scan reaches 6 before 7).
- `done` asserted while IDLE, req=0: no output change and `timeout`=0.
